// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction fetch stage (req/ack imem read, valid/ready IR); IFU_ALIGN_CHECK_EN enables misaligned-PC halt
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir,
    output logic [31:0] ir_pc,
    output logic        ir_valid,
    input  logic        ir_ready,
    input  logic        flush,
    output logic        pc_adv,
    output logic        misalign
);

`ifdef IFU_ALIGN_CHECK_EN
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        FULL = 3'd2,
        ADV  = 3'd3,
        HALT = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        FULL = 3'd2,
        ADV  = 3'd3
    } state_t;
`endif

    state_t      state;
    state_t      state_nxt;
    logic [31:0] addr_nxt;
    logic [31:0] ir_nxt;
    logic [31:0] ir_pc_nxt;
    // drop marks a request whose data must be discarded because a flush
    // arrived before the memory answered; the request itself is never abandoned
    logic        drop;
    logic        drop_nxt;

`ifdef IFU_ALIGN_CHECK_EN
    logic        misalign_nxt;
`else
    logic        unused_pc_lsb;
    assign unused_pc_lsb = ^pc[1:0];
    assign misalign = 1'b0;
`endif

    // Moore outputs decoded from the state register
    assign imem_req = (state == REQ);
    assign ir_valid = (state == FULL);
    assign pc_adv   = (state == ADV);

    // state and datapath registers, synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            imem_addr <= RESET_PC;
            ir        <= 32'h0;
            ir_pc     <= RESET_PC;
            drop      <= 1'b0;
`ifdef IFU_ALIGN_CHECK_EN
            misalign  <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            imem_addr <= addr_nxt;
            ir        <= ir_nxt;
            ir_pc     <= ir_pc_nxt;
            drop      <= drop_nxt;
`ifdef IFU_ALIGN_CHECK_EN
            misalign  <= misalign_nxt;
`endif
        end
    end

    // next-state logic; flush outranks both imem_ack and ir_ready
    always_comb begin
        state_nxt = state;
        addr_nxt  = imem_addr;
        ir_nxt    = ir;
        ir_pc_nxt = ir_pc;
        drop_nxt  = drop;
`ifdef IFU_ALIGN_CHECK_EN
        misalign_nxt = misalign;
`endif
        case (state)
            IDLE: begin
                if (!flush) begin
`ifdef IFU_ALIGN_CHECK_EN
                    if (pc[1:0] != 2'b00) begin
                        misalign_nxt = 1'b1;
                        state_nxt    = HALT;
                    end else begin
                        addr_nxt  = {pc[31:2], 2'b00};
                        state_nxt = REQ;
                    end
`else
                    addr_nxt  = {pc[31:2], 2'b00};
                    state_nxt = REQ;
`endif
                end
            end
            REQ: begin
                if (imem_ack) begin
                    if (drop || flush) begin
                        drop_nxt  = 1'b0;
                        state_nxt = IDLE;
                    end else begin
                        ir_nxt    = imem_rdata;
                        ir_pc_nxt = imem_addr;
                        state_nxt = FULL;
                    end
                end else if (flush) begin
                    drop_nxt = 1'b1;
                end
            end
            FULL: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else if (ir_ready) begin
                    state_nxt = ADV;
                end
            end
            ADV: begin
                state_nxt = IDLE;
            end
`ifdef IFU_ALIGN_CHECK_EN
            HALT: begin
                state_nxt = HALT;
            end
`endif
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// tb/tb_ifu_fetch.sv - self-checking bench for ifu_fetch (directed scenarios plus randomized run)
module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] ir;
    logic [31:0] ir_pc;
    logic        ir_valid;
    logic        ir_ready;
    logic        flush;
    logic        pc_adv;
    logic        misalign;

    int          vectors     = 0;
    int          miscompares = 0;
    int          adv_count   = 0;
    logic [31:0] flush_target = 32'h0000_3000;

    always #5 clk = ~clk;

    ifu_fetch dut (
        .clk        (clk),
        .rst        (rst),
        .pc         (pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .ir         (ir),
        .ir_pc      (ir_pc),
        .ir_valid   (ir_valid),
        .ir_ready   (ir_ready),
        .flush      (flush),
        .pc_adv     (pc_adv),
        .misalign   (misalign)
    );

    // instruction memory contents as a fixed function of the address
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // one clock; the bench plays the datapath: flush loads the redirect
    // target, otherwise pc_adv loads pc+4, both at the edge
    task automatic step();
        logic [31:0] npc;
        npc = pc;
        if (flush) npc = flush_target;
        else if (pc_adv) npc = pc + 32'd4;
        @(posedge clk);
        #1;
        pc = npc;
        if (pc_adv) adv_count++;
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; imem_ack = 1'b0; ir_ready = 1'b0; imem_rdata = 32'h0;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; imem_ack = 1'b0; ir_ready = 1'b0; imem_rdata = 32'h0;
        pc = 32'h0000_3200;
        step();
        step();
        vectors++;
        if ({imem_req, imem_addr, ir, ir_pc, ir_valid, pc_adv, misalign} !==
            {1'b0, 32'h3000, 32'h0, 32'h3000, 3'b000}) begin
            miscompares++;
            $display("FAIL reset_values got req=%0b addr=%h ir=%h ir_pc=%h v=%0b adv=%0b mis=%0b exp 0/3000/0/3000/0/0/0",
                     imem_req, imem_addr, ir, ir_pc, ir_valid, pc_adv, misalign);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        do_reset();
        pc = 32'h0000_3000;
        vectors++;
        if (imem_req !== 1'b0) begin miscompares++; $display("FAIL basic_idle_req got %0b exp 0", imem_req); end
        step();
        vectors++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h3000}) begin
            miscompares++; $display("FAIL basic_req got req=%0b addr=%h exp 1/3000", imem_req, imem_addr);
        end
        imem_ack = 1'b1; imem_rdata = 32'h2008_0005; ir_ready = 1'b1;
        step();
        imem_ack = 1'b0;
        vectors++;
        if ({ir_valid, ir, ir_pc, imem_req} !== {1'b1, 32'h2008_0005, 32'h3000, 1'b0}) begin
            miscompares++; $display("FAIL basic_full got v=%0b ir=%h ir_pc=%h req=%0b exp 1/20080005/3000/0",
                                    ir_valid, ir, ir_pc, imem_req);
        end
        step();
        vectors++;
        if ({pc_adv, ir_valid} !== 2'b10) begin
            miscompares++; $display("FAIL basic_adv got adv=%0b v=%0b exp 1/0", pc_adv, ir_valid);
        end
        step();
        vectors++;
        if ({pc_adv, imem_req, ir_valid} !== 3'b000) begin
            miscompares++; $display("FAIL basic_idle2 got adv=%0b req=%0b v=%0b exp 0/0/0", pc_adv, imem_req, ir_valid);
        end
        step();
        vectors++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h3004}) begin
            miscompares++; $display("FAIL basic_next_req got req=%0b addr=%h exp 1/3004", imem_req, imem_addr);
        end
        ir_ready = 1'b0;
    endtask

    task automatic test_stall();
        int adv0;
        do_reset();
        pc = 32'h0000_3100;
        adv0 = adv_count;
        step();
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if ({imem_req, imem_addr} !== {1'b1, 32'h3100}) begin
                miscompares++; $display("FAIL stall_req_hold[%0d] got req=%0b addr=%h exp 1/3100", i, imem_req, imem_addr);
            end
            if (i == 3) begin imem_ack = 1'b1; imem_rdata = 32'h1234_5678; end
            step();
        end
        imem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if ({ir_valid, ir, ir_pc, pc_adv} !== {1'b1, 32'h1234_5678, 32'h3100, 1'b0}) begin
                miscompares++; $display("FAIL stall_ir_hold[%0d] got v=%0b ir=%h ir_pc=%h adv=%0b exp 1/12345678/3100/0",
                                        i, ir_valid, ir, ir_pc, pc_adv);
            end
            ir_ready = (i == 2);
            step();
        end
        ir_ready = 1'b0;
        vectors++;
        if (pc_adv !== 1'b1) begin miscompares++; $display("FAIL stall_adv got %0b exp 1", pc_adv); end
        step();
        step();
        vectors++;
        if (adv_count - adv0 !== 1) begin
            miscompares++; $display("FAIL stall_adv_count got %0d exp 1", adv_count - adv0);
        end
    endtask

    task automatic test_flush_req();
        int adv0;
        do_reset();
        pc = 32'h0000_3000;
        adv0 = adv_count;
        step();
        flush = 1'b1; flush_target = 32'h0000_3040;
        step();
        flush = 1'b0;
        vectors++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h3000}) begin
            miscompares++; $display("FAIL flushreq_hold got req=%0b addr=%h exp 1/3000", imem_req, imem_addr);
        end
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_ack = 1'b0;
        vectors++;
        if ({imem_req, ir_valid, ir} !== {2'b00, 32'h0}) begin
            miscompares++; $display("FAIL flushreq_discard got req=%0b v=%0b ir=%h exp 0/0/00000000", imem_req, ir_valid, ir);
        end
        step();
        vectors++;
        if ({imem_req, imem_addr, ir_valid} !== {1'b1, 32'h3040, 1'b0}) begin
            miscompares++; $display("FAIL flushreq_redirect got req=%0b addr=%h v=%0b exp 1/3040/0", imem_req, imem_addr, ir_valid);
        end
        vectors++;
        if (adv_count !== adv0) begin
            miscompares++; $display("FAIL flushreq_no_adv got %0d exp %0d", adv_count, adv0);
        end
    endtask

    task automatic test_flush_full();
        int adv0;
        do_reset();
        pc = 32'h0000_3000;
        step();
        imem_ack = 1'b1; imem_rdata = 32'h1111_2222;
        step();
        imem_ack = 1'b0;
        adv0 = adv_count;
        vectors++;
        if (ir_valid !== 1'b1) begin miscompares++; $display("FAIL flushfull_valid got %0b exp 1", ir_valid); end
        flush = 1'b1; ir_ready = 1'b1; flush_target = 32'h0000_3000;
        step();
        flush = 1'b0; ir_ready = 1'b0;
        vectors++;
        if ({ir_valid, pc_adv} !== 2'b00) begin
            miscompares++; $display("FAIL flushfull_drop got v=%0b adv=%0b exp 0/0", ir_valid, pc_adv);
        end
        step();
        vectors++;
        if ({imem_req, imem_addr, pc_adv} !== {1'b1, 32'h3000, 1'b0}) begin
            miscompares++; $display("FAIL flushfull_refetch got req=%0b addr=%h adv=%0b exp 1/3000/0", imem_req, imem_addr, pc_adv);
        end
        vectors++;
        if (adv_count !== adv0) begin
            miscompares++; $display("FAIL flushfull_no_adv got %0d exp %0d", adv_count, adv0);
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 2; k++) begin
            do_reset();
            pc = 32'h0000_3100;
            step();
            if (k == 1) begin
                imem_ack = 1'b1; imem_rdata = 32'hCAFE_F00D;
                step();
                imem_ack = 1'b0;
            end
            rst = 1'b1;
            step();
            rst = 1'b0;
            vectors++;
            if ({imem_req, imem_addr, ir, ir_pc, ir_valid, pc_adv, misalign} !==
                {1'b0, 32'h3000, 32'h0, 32'h3000, 3'b000}) begin
                miscompares++;
                $display("FAIL reset_mid[%0d] got req=%0b addr=%h ir=%h ir_pc=%h v=%0b adv=%0b mis=%0b exp 0/3000/0/3000/0/0/0",
                         k, imem_req, imem_addr, ir, ir_pc, ir_valid, pc_adv, misalign);
            end
            step();
            vectors++;
            if ({imem_req, imem_addr} !== {1'b1, 32'h3100}) begin
                miscompares++; $display("FAIL reset_mid_restart[%0d] got req=%0b addr=%h exp 1/3100", k, imem_req, imem_addr);
            end
        end
    endtask

    task automatic test_misalign();
        do_reset();
        pc = 32'h0000_3002;
        flush_target = 32'h0000_3002;
        step();
`ifdef IFU_ALIGN_CHECK_EN
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if ({imem_req, misalign, ir_valid, pc_adv} !== 4'b0100) begin
                miscompares++; $display("FAIL misalign_halt[%0d] got req=%0b mis=%0b v=%0b adv=%0b exp 0/1/0/0",
                                        i, imem_req, misalign, ir_valid, pc_adv);
            end
            flush = i[0]; ir_ready = 1'b1;
            step();
        end
        flush = 1'b0; ir_ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        vectors++;
        if (misalign !== 1'b0) begin miscompares++; $display("FAIL misalign_clear got %0b exp 0", misalign); end
`else
        vectors++;
        if ({imem_req, imem_addr, misalign} !== {1'b1, 32'h3000, 1'b0}) begin
            miscompares++; $display("FAIL misalign_off got req=%0b addr=%h mis=%0b exp 1/3000/0", imem_req, imem_addr, misalign);
        end
        imem_ack = 1'b1; imem_rdata = 32'h0BAD_0001;
        step();
        imem_ack = 1'b0;
        vectors++;
        if ({ir_valid, ir_pc, misalign} !== {1'b1, 32'h3000, 1'b0}) begin
            miscompares++; $display("FAIL misalign_off_fetch got v=%0b ir_pc=%h mis=%0b exp 1/3000/0", ir_valid, ir_pc, misalign);
        end
`endif
    endtask

    // random run: memory with random latency, random ready and flushes;
    // every delivered instruction must be the word at the architectural pc
    task automatic test_random();
        logic        prev_req   = 1'b0;
        logic        prev_valid = 1'b0;
        logic        prev_hs    = 1'b0;
        logic        exp_valid  = 1'b0;
        logic        exp_valid_n;
        logic        killed     = 1'b0;
        logic        hs;
        logic [31:0] req_addr   = 32'h0;
        logic [31:0] exp_ir     = 32'h0;
        logic [31:0] exp_irpc   = 32'h0;
        logic [31:0] held_ir    = 32'h0;
        logic [31:0] held_irpc  = 32'h0;
        int          wait_n     = 0;
        int          delivered  = 0;
        int          hs_total   = 0;
        int          adv0;
        do_reset();
        pc = 32'h0000_3000;
        adv0 = adv_count;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (exp_valid) begin
                vectors++;
                if ({ir_valid, ir, ir_pc} !== {1'b1, exp_ir, exp_irpc}) begin
                    miscompares++; $display("FAIL rnd_deliver cyc=%0d got v=%0b ir=%h ir_pc=%h exp 1/%h/%h",
                                            cyc, ir_valid, ir, ir_pc, exp_ir, exp_irpc);
                end
            end
            if (ir_valid && !prev_valid) begin
                delivered++;
                vectors++;
                if (!exp_valid || ir !== mem_word(pc) || ir_pc !== pc) begin
                    miscompares++; $display("FAIL rnd_arch cyc=%0d got ir=%h ir_pc=%h exp %h/%h expected_delivery=%0b",
                                            cyc, ir, ir_pc, mem_word(pc), pc, exp_valid);
                end
            end
            if (ir_valid && prev_valid) begin
                vectors++;
                if ({ir, ir_pc} !== {held_ir, held_irpc}) begin
                    miscompares++; $display("FAIL rnd_ir_stable cyc=%0d got %h/%h exp %h/%h", cyc, ir, ir_pc, held_ir, held_irpc);
                end
            end
            vectors++;
            if (pc_adv !== prev_hs) begin
                miscompares++; $display("FAIL rnd_pc_adv cyc=%0d got %0b exp %0b", cyc, pc_adv, prev_hs);
            end
            if (imem_req) begin
                vectors++;
                if (!prev_req) begin
                    if (imem_addr !== pc) begin
                        miscompares++; $display("FAIL rnd_req_addr cyc=%0d got %h exp %h", cyc, imem_addr, pc);
                    end
                    req_addr = imem_addr;
                    wait_n   = $urandom_range(0, 3);
                    killed   = 1'b0;
                end else if (imem_addr !== req_addr) begin
                    miscompares++; $display("FAIL rnd_addr_stable cyc=%0d got %h exp %h", cyc, imem_addr, req_addr);
                end
            end
            flush        = ($urandom_range(0, 99) < 5);
            flush_target = 32'h0000_3000 + ($urandom_range(0, 255) << 2);
            ir_ready     = ($urandom_range(0, 99) < 65);
            imem_ack     = imem_req && (wait_n == 0);
            if (imem_req && wait_n > 0) wait_n--;
            imem_rdata   = imem_ack ? mem_word(req_addr) : $urandom;
            exp_valid_n  = imem_ack && !killed && !flush;
            exp_ir       = mem_word(req_addr);
            exp_irpc     = req_addr;
            if (imem_req && flush) killed = 1'b1;
            hs = ir_valid && ir_ready && !flush;
            if (hs) hs_total++;
            prev_req   = imem_req;
            prev_valid = ir_valid;
            held_ir    = ir;
            held_irpc  = ir_pc;
            prev_hs    = hs;
            step();
            exp_valid = exp_valid_n;
        end
        flush = 1'b0; imem_ack = 1'b0; ir_ready = 1'b0;
        step();
        vectors++;
        if (delivered < 100) begin
            miscompares++; $display("FAIL rnd_progress got %0d deliveries exp at least 100", delivered);
        end
        vectors++;
        if (adv_count - adv0 !== hs_total) begin
            miscompares++; $display("FAIL rnd_adv_total got %0d exp %0d", adv_count - adv0, hs_total);
        end
    endtask

    initial begin
        rst = 1'b1; pc = 32'h0000_3000; flush = 1'b0;
        imem_ack = 1'b0; imem_rdata = 32'h0; ir_ready = 1'b0;
        test_reset();
        test_basic();
        test_stall();
        test_flush_req();
        test_flush_full();
        test_reset_mid();
        test_misalign();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
